// File: rtl/riscv_processor.sv
// Five-stage pipelined 32-bit CPU (IF/ID/EX/MEM/WB) with one unified word-addressed memory.
// Full forwarding, one-cycle load-use interlock, branches resolved in MEM, HLT freezes the machine.
module riscv_processor #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        halted,
    output logic [31:0] pc
);
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3;
    localparam logic [5:0] OP_SLT = 6'd4, OP_MUL = 6'd5, OP_LW = 6'd8, OP_SW = 6'd9;
    localparam logic [5:0] OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:2**ADDR_W-1];

    logic [31:0] pc_q;
    logic        halted_q, stop_q;
    logic        ifid_valid_q;
    logic [31:0] ifid_ir_q, ifid_npc_q;
    logic        idex_valid_q, idex_wen_q;
    logic [5:0]  idex_op_q;
    logic [4:0]  idex_rs_q, idex_rt_q, idex_dest_q;
    logic [31:0] idex_a_q, idex_b_q, idex_imm_q, idex_npc_q;
    logic        exmem_valid_q, exmem_wen_q, exmem_cond_q;
    logic [5:0]  exmem_op_q;
    logic [4:0]  exmem_dest_q;
    logic [31:0] exmem_alu_q, exmem_b_q, exmem_target_q;
    logic        memwb_valid_q, memwb_wen_q, memwb_halt_q;
    logic [4:0]  memwb_dest_q;
    logic [31:0] memwb_data_q;

    // WB
    logic wb_we;
    assign wb_we = memwb_valid_q && memwb_wen_q && (|memwb_dest_q) && !halted_q && !rst;

    // ID: decode and write-through register read
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd, id_dest;
    logic [31:0] id_imm, id_a, id_b;
    logic        id_wen, id_use_rs, id_use_rt, id_hlt, load_use, fetch_stop;
    assign id_op  = ifid_ir_q[31:26];
    assign id_rs  = ifid_ir_q[25:21];
    assign id_rt  = ifid_ir_q[20:16];
    assign id_rd  = ifid_ir_q[15:11];
    assign id_imm = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};

    always_comb begin
        id_wen    = 1'b0;
        id_dest   = id_rd;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_wen = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                id_wen = 1'b1; id_dest = id_rt; id_use_rs = 1'b1;
            end
            OP_SW:             begin id_use_rs = 1'b1; id_use_rt = 1'b1; end
            OP_BNEQZ, OP_BEQZ: id_use_rs = 1'b1;
            default: ;
        endcase
        id_a = (id_rs == 5'd0) ? 32'd0 : (wb_we && memwb_dest_q == id_rs) ? memwb_data_q : Reg[id_rs];
        id_b = (id_rt == 5'd0) ? 32'd0 : (wb_we && memwb_dest_q == id_rt) ? memwb_data_q : Reg[id_rt];
    end

    assign id_hlt     = ifid_valid_q && id_op == OP_HLT;
    assign fetch_stop = stop_q || id_hlt;
    // Load data only exists after MEM, so a dependent instruction right behind an LW waits one cycle.
    assign load_use   = idex_valid_q && idex_op_q == OP_LW && (|idex_dest_q) && ifid_valid_q &&
                        ((id_use_rs && id_rs == idex_dest_q) || (id_use_rt && id_rt == idex_dest_q));

    // EX: forwarding (EX/MEM first, then MEM/WB) and ALU
    logic        fwd_em, fwd_mw;
    logic [31:0] ex_a, ex_b, ex_alu, ex_target;
    logic        ex_cond;
    assign fwd_em = exmem_valid_q && exmem_wen_q && (|exmem_dest_q) && exmem_op_q != OP_LW;
    assign fwd_mw = memwb_valid_q && memwb_wen_q && (|memwb_dest_q);

    always_comb begin
        ex_a = idex_a_q;
        if (fwd_em && exmem_dest_q == idex_rs_q)      ex_a = exmem_alu_q;
        else if (fwd_mw && memwb_dest_q == idex_rs_q) ex_a = memwb_data_q;
        ex_b = idex_b_q;
        if (fwd_em && exmem_dest_q == idex_rt_q)      ex_b = exmem_alu_q;
        else if (fwd_mw && memwb_dest_q == idex_rt_q) ex_b = memwb_data_q;
        ex_alu = '0;
        case (idex_op_q)
            OP_ADD:               ex_alu = ex_a + ex_b;
            OP_SUB:               ex_alu = ex_a - ex_b;
            OP_AND:               ex_alu = ex_a & ex_b;
            OP_OR:                ex_alu = ex_a | ex_b;
            OP_SLT:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
            OP_MUL:               ex_alu = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + idex_imm_q;
            OP_SUBI:              ex_alu = ex_a - idex_imm_q;
            OP_SLTI:              ex_alu = {31'd0, $signed(ex_a) < $signed(idex_imm_q)};
            default:              ex_alu = '0;
        endcase
        ex_cond = (idex_op_q == OP_BNEQZ) ? (ex_a != 32'd0) : (ex_a == 32'd0);
    end
    assign ex_target = idex_npc_q + idex_imm_q;

    // MEM
    logic        taken_branch, mem_we;
    logic [31:0] mem_rdata;
    assign taken_branch = exmem_valid_q && (exmem_op_q == OP_BNEQZ || exmem_op_q == OP_BEQZ) && exmem_cond_q;
    assign mem_we       = exmem_valid_q && exmem_op_q == OP_SW && !halted_q && !rst;
    assign mem_rdata    = Mem[exmem_alu_q[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wb_we)  Reg[memwb_dest_q] <= memwb_data_q;
        if (mem_we) Mem[exmem_alu_q[ADDR_W-1:0]] <= exmem_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            halted_q      <= 1'b0;
            stop_q        <= 1'b0;
            ifid_valid_q  <= 1'b0;
            idex_valid_q  <= 1'b0;
            exmem_valid_q <= 1'b0;
            memwb_valid_q <= 1'b0;
        end else if (!halted_q) begin
            // A taken branch in MEM overrides everything younger, including a pending HLT.
            if (taken_branch)                pc_q <= exmem_target_q;
            else if (!load_use && !fetch_stop) pc_q <= pc_q + 32'd1;
            stop_q <= taken_branch ? 1'b0 : fetch_stop;

            if (taken_branch || fetch_stop) ifid_valid_q <= 1'b0;
            else if (!load_use) begin
                ifid_valid_q <= 1'b1;
                ifid_ir_q    <= Mem[pc_q[ADDR_W-1:0]];
                ifid_npc_q   <= pc_q + 32'd1;
            end

            idex_valid_q <= ifid_valid_q && !taken_branch && !load_use;
            idex_op_q    <= id_op;
            idex_rs_q    <= id_rs;
            idex_rt_q    <= id_rt;
            idex_dest_q  <= id_dest;
            idex_wen_q   <= id_wen;
            idex_a_q     <= id_a;
            idex_b_q     <= id_b;
            idex_imm_q   <= id_imm;
            idex_npc_q   <= ifid_npc_q;

            exmem_valid_q  <= idex_valid_q && !taken_branch;
            exmem_op_q     <= idex_op_q;
            exmem_dest_q   <= idex_dest_q;
            exmem_wen_q    <= idex_wen_q;
            exmem_alu_q    <= ex_alu;
            exmem_b_q      <= ex_b;
            exmem_cond_q   <= ex_cond;
            exmem_target_q <= ex_target;

            memwb_valid_q <= exmem_valid_q;
            memwb_dest_q  <= exmem_dest_q;
            memwb_wen_q   <= exmem_wen_q;
            memwb_data_q  <= (exmem_op_q == OP_LW) ? mem_rdata : exmem_alu_q;
            memwb_halt_q  <= exmem_op_q == OP_HLT;

            halted_q <= memwb_valid_q && memwb_halt_q;
        end
    end

    assign halted = halted_q;
    assign pc     = pc_q;
endmodule

// File: tb/tb_riscv_processor.sv
// Directed-program bench for riscv_processor: preloads Reg/Mem hierarchically, runs to HLT,
// and checks registers, memory, cycle counts (stall/branch penalties) and the frozen PC.
module tb_riscv_processor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] pc;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_processor #(.ADDR_W(10)) dut (
    .clk(clk),
    .rst(rst),
    .halted(halted),
    .pc(pc)
  );

  function automatic logic [31:0] enc_r(int op, int rs, int rt, int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Holds reset, clears memory and sets Reg[k] = k.
  task automatic prep();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    prep();
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pc !== 32'd3) begin bad++; $display("FAIL reset_pc_run got=%0d want=3", pc); end
  endtask

  task automatic load_prog1();
    logic [31:0] p [9] = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h0ce77800, 32'h0ce77800,
                           32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    for (int i = 0; i < 9; i++) dut.Mem[i] = p[i];
  endtask

  task automatic test_program1();
    int cyc;
    logic [31:0] re [6] = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd30, 32'd60};
    prep(); load_prog1(); start();
    run_until_halt(cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL p1_cycles got=%0d want=13", cyc); end
    total++; if (pc !== 32'd9) begin bad++; $display("FAIL p1_pc got=%0d want=9", pc); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (dut.Reg[k] !== re[k]) begin bad++; $display("FAIL p1_r%0d got=%0d want=%0d", k, dut.Reg[k], re[k]); end
    end
    repeat (20) @(posedge clk);
    #1;
    total++; if (pc !== 32'd9 || halted !== 1'b1) begin bad++; $display("FAIL p1_frozen pc=%0d halted=%b want pc=9 halted=1", pc, halted); end
  endtask

  task automatic test_forward();
    int cyc;
    prep();
    dut.Mem[0] = enc_i(10, 0, 1, 5);
    dut.Mem[1] = enc_r(0, 1, 1, 2);
    dut.Mem[2] = enc_r(5, 2, 2, 3);
    dut.Mem[3] = enc_i(63, 0, 0, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 8) begin bad++; $display("FAIL fwd_cycles got=%0d want=8", cyc); end
    total++; if (dut.Reg[2] !== 32'd10) begin bad++; $display("FAIL fwd_r2 got=%0d want=10", dut.Reg[2]); end
    total++; if (dut.Reg[3] !== 32'd100) begin bad++; $display("FAIL fwd_r3 got=%0d want=100", dut.Reg[3]); end
  endtask

  task automatic test_load_use();
    int cyc;
    prep();
    dut.Mem[100] = 32'd7;
    dut.Mem[0] = enc_i(10, 0, 1, 100);
    dut.Mem[1] = enc_i(8, 1, 2, 0);
    dut.Mem[2] = enc_r(0, 2, 2, 3);
    dut.Mem[3] = enc_i(9, 1, 3, 1);
    dut.Mem[4] = enc_i(63, 0, 0, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL lu_cycles got=%0d want=10", cyc); end
    total++; if (dut.Reg[2] !== 32'd7) begin bad++; $display("FAIL lu_r2 got=%0d want=7", dut.Reg[2]); end
    total++; if (dut.Reg[3] !== 32'd14) begin bad++; $display("FAIL lu_r3 got=%0d want=14", dut.Reg[3]); end
    total++; if (dut.Mem[101] !== 32'd14) begin bad++; $display("FAIL lu_mem101 got=%0d want=14", dut.Mem[101]); end
  endtask

  task automatic test_loop();
    int cyc;
    prep();
    dut.Mem[0] = enc_i(10, 0, 1, 3);
    dut.Mem[1] = enc_i(11, 1, 1, 1);
    dut.Mem[2] = enc_i(13, 1, 0, -2);
    dut.Mem[3] = enc_i(10, 0, 4, 9);
    dut.Mem[4] = enc_i(63, 0, 0, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 19) begin bad++; $display("FAIL loop_cycles got=%0d want=19", cyc); end
    total++; if (dut.Reg[1] !== 32'd0) begin bad++; $display("FAIL loop_r1 got=%0d want=0", dut.Reg[1]); end
    total++; if (dut.Reg[4] !== 32'd9) begin bad++; $display("FAIL loop_r4 got=%0d want=9", dut.Reg[4]); end
  endtask

  task automatic test_branch_squash();
    int cyc;
    prep();
    dut.Mem[0] = enc_i(10, 0, 1, 1);
    dut.Mem[1] = enc_i(13, 1, 0, 3);
    dut.Mem[2] = enc_i(10, 0, 7, 5);
    dut.Mem[3] = enc_i(10, 0, 8, 6);
    dut.Mem[4] = enc_i(10, 0, 9, 7);
    dut.Mem[5] = enc_i(10, 0, 10, 8);
    dut.Mem[6] = enc_i(63, 0, 0, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 11) begin bad++; $display("FAIL sq_cycles got=%0d want=11", cyc); end
    for (int k = 7; k < 10; k++) begin
      total++;
      if (dut.Reg[k] !== k) begin bad++; $display("FAIL sq_r%0d got=%0d want=%0d", k, dut.Reg[k], k); end
    end
    total++; if (dut.Reg[10] !== 32'd8) begin bad++; $display("FAIL sq_r10 got=%0d want=8", dut.Reg[10]); end
  endtask

  task automatic test_alu();
    int cyc;
    int ri [11] = '{0, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    logic [31:0] re [11] = '{32'd0, 32'hFFFFFFF8, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0,
                             32'hFFFFFFFE, 32'd4, 32'd12, 32'd3};
    prep();
    dut.Reg[1] = 32'hFFFFFFFB;
    dut.Reg[2] = 32'd3;
    dut.Reg[3] = 32'h00010000;
    dut.Mem[0]  = enc_r(1, 1, 2, 4);
    dut.Mem[1]  = enc_r(2, 1, 2, 5);
    dut.Mem[2]  = enc_r(4, 1, 2, 6);
    dut.Mem[3]  = enc_r(4, 2, 1, 7);
    dut.Mem[4]  = enc_i(12, 2, 8, -1);
    dut.Mem[5]  = enc_r(5, 3, 3, 9);
    dut.Mem[6]  = enc_i(10, 0, 0, 5);
    dut.Mem[7]  = enc_r(0, 0, 2, 13);
    dut.Mem[8]  = enc_i(11, 2, 10, 5);
    dut.Mem[9]  = enc_i(14, 2, 0, 5);
    dut.Mem[10] = enc_i(10, 0, 11, 4);
    dut.Mem[11] = enc_r(7, 2, 2, 12);
    dut.Mem[12] = enc_i(63, 0, 0, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 17) begin bad++; $display("FAIL alu_cycles got=%0d want=17", cyc); end
    for (int k = 0; k < 11; k++) begin
      total++;
      if (dut.Reg[ri[k]] !== re[k]) begin bad++; $display("FAIL alu_r%0d got=%h want=%h", ri[k], dut.Reg[ri[k]], re[k]); end
    end
  endtask

  task automatic test_halt_guard();
    int cyc;
    prep();
    dut.Mem[0] = enc_i(63, 0, 0, 0);
    dut.Mem[1] = enc_i(10, 0, 6, 1);
    dut.Mem[2] = enc_i(9, 0, 6, 0);
    start();
    run_until_halt(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL hg_cycles got=%0d want=5", cyc); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL hg_halted got=%b want=1", halted); end
    total++; if (pc !== 32'd1) begin bad++; $display("FAIL hg_pc got=%0d want=1", pc); end
    total++; if (dut.Reg[6] !== 32'd6) begin bad++; $display("FAIL hg_r6 got=%0d want=6", dut.Reg[6]); end
    total++; if (dut.Mem[0] !== 32'hfc000000) begin bad++; $display("FAIL hg_mem0 got=%h want=fc000000", dut.Mem[0]); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    prep(); load_prog1(); start();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL mr_pc got=%0d want=0", pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL mr_halted got=%b want=0", halted); end
    rst = 1'b0;
    run_until_halt(cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL mr_cycles got=%0d want=13", cyc); end
    total++; if (dut.Reg[4] !== 32'd30) begin bad++; $display("FAIL mr_r4 got=%0d want=30", dut.Reg[4]); end
    total++; if (dut.Reg[5] !== 32'd60) begin bad++; $display("FAIL mr_r5 got=%0d want=60", dut.Reg[5]); end
  endtask

  initial begin
    test_reset();
    test_program1();
    test_forward();
    test_load_use();
    test_loop();
    test_branch_squash();
    test_alu();
    test_halt_guard();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
